fpga_spi_slave_rx: RTL and testbench
====================================

Name: fpga_spi_slave_rx

Overview:
SPI slave front end between the Hercules MCU SPI master and the FPGA main control block. It synchronizes the external SCLK/CS/MOSI pins into sysClk and deserializes MSB-first bytes. Each byte is presented with its index in the frame as the spi_byte / spi_input_valid / spi_byte_num stream. It also shifts a status/echo byte out on MISO and flags malformed frames (short frames, over-long frames).

Parameters:
FRAME_BYTES, 9, bytes per command frame; legal range 1..16, since the index is 4 bits.
SYNC_STAGES, 2, flip-flop stages in each input pin synchronizer; minimum 2.

Ports:
sysClk  in  1  system clock; all logic on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
spi_sclk  in  1  SPI clock from the master, mode 0 (CPOL=0, CPHA=0); asynchronous to sysClk.
spi_cs_n  in  1  chip select, active low; asynchronous.
spi_mosi  in  1  master-out data; asynchronous.
spi_miso  out  1  slave-out data.
tx_byte  in  8  byte to transmit next on MISO.
tx_byte_ack  out  1  one-cycle pulse when tx_byte has been captured into the TX shifter.
spi_byte  out  8  last received byte.
spi_input_valid  out  1  one-cycle pulse: spi_byte and spi_byte_num are valid.
spi_byte_num  out  4  index of spi_byte within the frame, 0..FRAME_BYTES-1.
frame_done  out  1  one-cycle pulse coincident with the valid pulse for byte FRAME_BYTES-1.
frame_error  out  1  one-cycle pulse when CS rises on a short or partial frame.
overflow  out  1  one-cycle pulse per extra byte received beyond FRAME_BYTES.

Behaviour:
- Reset values: all outputs 0, except spi_miso = 0. bit_cnt = 0, byte_cnt = 0, all shifters = 0. All synchronizer flops reset to the idle pin level: sclk 0, cs_n 1, mosi 0.
- Constraint: the SCLK frequency is at most sysClk/8. Faster SCLK is out of scope.
- Synchronization: each pin passes through SYNC_STAGES flops, plus one history flop for edge detection. Events derived from the synchronized signals:
  - sclk_rise, sclk_fall
  - cs_fall, cs_rise
  - active = synchronized cs_n is low
- States: IDLE, ACTIVE.
  - IDLE -> ACTIVE on cs_fall.
  - ACTIVE -> IDLE on cs_rise.
- cs_fall:
  - Clear bit_cnt and byte_cnt.
  - Load the TX shifter with tx_byte and pulse tx_byte_ack.
  - Drive spi_miso from TX shifter bit 7 in the following cycle.
- sclk_rise while ACTIVE:
  - Shift the synchronized MOSI into RX shift register bit 0 (MSB first).
  - bit_cnt increments and wraps 7 -> 0.
- Byte completion, on the sclk_rise where bit_cnt = 7, with outputs registered at that sysClk edge:
  - If byte_cnt < FRAME_BYTES:
    - spi_byte = the assembled byte, spi_byte_num = byte_cnt, spi_input_valid = 1 for one cycle.
    - frame_done = 1 in the same cycle if byte_cnt = FRAME_BYTES-1.
    - byte_cnt increments.
  - Else: overflow = 1 for one cycle; no valid pulse; byte_cnt saturates at FRAME_BYTES.
  - In both cases, reload the TX shifter with tx_byte and pulse tx_byte_ack.
- spi_byte and spi_byte_num hold their values between valid pulses.
- Latency: spi_input_valid is asserted no more than SYNC_STAGES+2 sysClk cycles after the 8th SCLK rising edge at the pin.
- sclk_fall while ACTIVE, and not on a byte boundary that just reloaded: shift the TX shifter left; spi_miso = new bit 7.
- cs_rise:
  - If bit_cnt != 0, or 0 < byte_cnt < FRAME_BYTES: pulse frame_error and discard the partial byte (no valid pulse).
  - A CS pulse carrying zero bytes is not an error.
  - Counters clear to 0.
- SCLK edges while CS is high (IDLE) are ignored.
- Simultaneous events in one sysClk cycle:
  - cs_rise with byte completion: the completion is processed first, then frame termination is evaluated on the updated counters.
  - cs_fall wins over any sclk edge.
- Reset asserted mid-frame: everything returns immediately to reset values. The next frame starts at byte_num 0 only after a fresh cs_fall. If CS is already low at reset release, stay in IDLE until the next cs_fall.

Decomposition:
- Shared package spi_pkg:
  - FRAME_BYTES default.
  - SPI state encoding (IDLE, ACTIVE).
  - Byte index width (4).
- One natural sub-module: fpga_pin_sync. It is a SYNC_STAGES-deep synchronizer with a parameterized reset level and rise/fall pulse outputs, instantiated three times.

Test Plan:
1. Full frame: tx_byte = 0x5A, 9 bytes 03 A1 8E FE 6F A6 36 1A AA, SCLK = sysClk/10 -> 9 valid pulses with spi_byte_num 0..8 and matching bytes; frame_done only with byte 8 (0xAA); frame_error = 0, overflow = 0.
2. MISO echo: tx_byte = 0x5A held for the whole frame -> master samples 0x5A on every byte; tx_byte_ack pulses 10 times (on cs_fall, then after each of the 9 bytes).
3. Abort: bytes 03 A1 8E plus 5 bits, then CS high -> 3 valid pulses, then frame_error pulse with no 4th valid. The next full frame reports byte_num starting at 0.
4. Over-long frame: 10 bytes, 10th = 0x55 -> 9 valid pulses, frame_done on byte 8, one overflow pulse, spi_byte still 0xAA; no frame_error at CS rise.
5. Reset mid-frame: reset_n low after byte 4, release with CS still low, finish clocking -> all outputs 0, no valid pulses until a new CS low, then a correct frame from byte_num 0.
6. Back-to-back frames with CS high for 2 SCLK periods, and SCLK toggling while CS is high -> two clean 9-byte frames; the idle SCLK toggles produce no events.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave receive path:
//   - default number of bytes in a command frame
//   - frame state encoding (IDLE / ACTIVE)
//   - byte index width and the wider byte counter width
//     (the counter saturates at FRAME_BYTES, which may be 16)
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int FRAME_BYTES_DEF = 9;
   localparam int IDX_W           = 4;
   localparam int CNT_W           = IDX_W + 1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_t;

   typedef logic [IDX_W-1:0] byte_idx_t;

endpackage

// File: rtl/fpga_pin_sync.sv
// -----------------------------------------------------------------------------
// fpga_pin_sync
// Multi-stage synchronizer for one asynchronous input pin, followed by a
// history flop that turns level changes into single-cycle edge pulses.
// Every flop resets to RESET_VAL (the idle level of the pin), so leaving
// reset never manufactures an edge on an idle pin.
//
// Ports:
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset
//   pin    in   raw asynchronous pin
//   level  out  synchronized pin level
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
//   fall   out  one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module fpga_pin_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_reg;
   logic              hist_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= {STAGES{RESET_VAL}};
         hist_reg <= RESET_VAL;
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], pin};
         hist_reg <= sync_reg[STAGES-1];
      end
   end

   assign level = sync_reg[STAGES-1];
   assign rise  =  level & ~hist_reg;
   assign fall  = ~level &  hist_reg;

endmodule

// File: rtl/fpga_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// fpga_spi_slave_rx
// SPI mode-0 slave front end. The SCLK / CS / MOSI pins are synchronized into
// sysClk; MSB-first bytes are deserialized and presented with their index in
// the frame. A status/echo byte (tx_byte) is shifted out on MISO, reloaded at
// CS fall and at every byte boundary. Short/partial frames and extra bytes
// beyond FRAME_BYTES are flagged.
//
// Ports:
//   sysClk           in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   spi_sclk         in   SPI clock (CPOL=0, CPHA=0), asynchronous
//   spi_cs_n         in   chip select, active low, asynchronous
//   spi_mosi         in   master-out data, asynchronous
//   spi_miso         out  slave-out data (TX shifter bit 7)
//   tx_byte          in   next byte to transmit
//   tx_byte_ack      out  pulse: tx_byte captured into the TX shifter
//   spi_byte         out  last received byte (held between valid pulses)
//   spi_input_valid  out  pulse: spi_byte / spi_byte_num valid
//   spi_byte_num     out  index of spi_byte within the frame
//   frame_done       out  pulse with the valid of byte FRAME_BYTES-1
//   frame_error      out  pulse: CS rose on a short or partial frame
//   overflow         out  pulse: byte received beyond FRAME_BYTES
// -----------------------------------------------------------------------------
module fpga_spi_slave_rx
   import spi_pkg::*;
#(
   parameter int FRAME_BYTES = FRAME_BYTES_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             sysClk,
   input  logic             reset_n,
   input  logic             spi_sclk,
   input  logic             spi_cs_n,
   input  logic             spi_mosi,
   output logic             spi_miso,
   input  logic [7:0]       tx_byte,
   output logic             tx_byte_ack,
   output logic [7:0]       spi_byte,
   output logic             spi_input_valid,
   output logic [IDX_W-1:0] spi_byte_num,
   output logic             frame_done,
   output logic             frame_error,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] FB_CNT  = CNT_W'(FRAME_BYTES);
   localparam logic [CNT_W-1:0] FB_LAST = CNT_W'(FRAME_BYTES - 1);

   // Pin bundle: bit 0 = sclk, bit 1 = cs_n, bit 2 = mosi.
   localparam logic [2:0] PIN_IDLE = 3'b010;

   logic [2:0] pin_raw;
   logic [2:0] pin_level;
   logic [2:0] pin_rise;
   logic [2:0] pin_fall;

   assign pin_raw = {spi_mosi, spi_cs_n, spi_sclk};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_sync
         fpga_pin_sync #(
            .STAGES    (SYNC_STAGES),
            .RESET_VAL (PIN_IDLE[gi])
         ) u_sync (
            .clk   (sysClk),
            .rst_n (reset_n),
            .pin   (pin_raw[gi]),
            .level (pin_level[gi]),
            .rise  (pin_rise[gi]),
            .fall  (pin_fall[gi])
         );
      end
   endgenerate

   logic sig_unused;
   assign sig_unused = &{1'b0, pin_level[0], pin_rise[2], pin_fall[2]};

   // -------------------------------------------------------------------------
   // CS arming. The cs_n synchronizer resets to 1; if the pin is already low
   // when reset releases, the chain would report a fake cs_fall. A CS fall is
   // only honoured once the synchronizer has settled and CS has truly been
   // seen high since reset.
   // -------------------------------------------------------------------------
   logic [SYNC_STAGES:0] settle_reg;
   logic                 armed_reg;
   logic                 settled;

   assign settled = settle_reg[SYNC_STAGES];

   always_ff @(posedge sysClk or negedge reset_n) begin
      if (!reset_n) begin
         settle_reg <= '0;
         armed_reg  <= 1'b0;
      end else begin
         settle_reg <= {settle_reg[SYNC_STAGES-1:0], 1'b1};
         if (settled && pin_level[1])
            armed_reg <= 1'b1;
      end
   end

   logic sclk_rise;
   logic sclk_fall;
   logic cs_fall;
   logic cs_rise;
   logic mosi_bit;

   assign sclk_rise = pin_rise[0];
   assign sclk_fall = pin_fall[0];
   assign cs_fall   = pin_fall[1] & armed_reg;
   assign cs_rise   = pin_rise[1];
   assign mosi_bit  = pin_level[2];

   // -------------------------------------------------------------------------
   // Frame FSM: state register / next state / outputs
   // -------------------------------------------------------------------------
   spi_state_t state_reg;
   spi_state_t state_next;
   logic       in_frame;

   always_ff @(posedge sysClk or negedge reset_n) begin
      if (!reset_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (cs_fall) state_next = ACTIVE;
         ACTIVE:  if (cs_rise) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_frame = (state_reg == ACTIVE);
   end

   // -------------------------------------------------------------------------
   // Datapath
   // -------------------------------------------------------------------------
   logic [2:0]       bit_cnt_reg,  bit_cnt_next;
   logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
   logic [7:0]       rx_shift_reg, rx_shift_next;
   logic [7:0]       tx_shift_reg, tx_shift_next;
   logic             skip_reg,     skip_next;
   logic [7:0]       byte_out_reg, byte_out_next;
   byte_idx_t        byte_num_reg, byte_num_next;
   logic             valid_reg,    valid_next;
   logic             done_reg,     done_next;
   logic             error_reg,    error_next;
   logic             ovf_reg,      ovf_next;
   logic             ack_reg,      ack_next;

   always_comb begin
      bit_cnt_next  = bit_cnt_reg;
      byte_cnt_next = byte_cnt_reg;
      rx_shift_next = rx_shift_reg;
      tx_shift_next = tx_shift_reg;
      skip_next     = skip_reg;
      byte_out_next = byte_out_reg;
      byte_num_next = byte_num_reg;
      valid_next    = 1'b0;
      done_next     = 1'b0;
      error_next    = 1'b0;
      ovf_next      = 1'b0;
      ack_next      = 1'b0;

      if (cs_fall) begin
         // Start of frame; any coincident SCLK edge is ignored.
         bit_cnt_next  = '0;
         byte_cnt_next = '0;
         rx_shift_next = '0;
         tx_shift_next = tx_byte;
         skip_next     = 1'b0;
         ack_next      = 1'b1;
      end else if (in_frame) begin
         if (sclk_rise) begin
            rx_shift_next = {rx_shift_reg[6:0], mosi_bit};
            bit_cnt_next  = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
               if (byte_cnt_reg < FB_CNT) begin
                  byte_out_next = rx_shift_next;
                  byte_num_next = byte_cnt_reg[IDX_W-1:0];
                  valid_next    = 1'b1;
                  done_next     = (byte_cnt_reg == FB_LAST);
                  byte_cnt_next = byte_cnt_reg + CNT_W'(1);
               end else begin
                  ovf_next      = 1'b1;
               end
               // MISO already shows the new bit 7; the falling edge that
               // follows this rising edge must not shift it away.
               tx_shift_next = tx_byte;
               skip_next     = 1'b1;
               ack_next      = 1'b1;
            end
         end else if (sclk_fall) begin
            if (skip_reg)
               skip_next = 1'b0;
            else
               tx_shift_next = {tx_shift_reg[6:0], 1'b0};
         end

         // Frame end is judged on the counters after any same-cycle byte
         // completion above.
         if (cs_rise) begin
            if ((bit_cnt_next != 3'd0) ||
                ((byte_cnt_next != '0) && (byte_cnt_next < FB_CNT)))
               error_next = 1'b1;
            bit_cnt_next  = '0;
            byte_cnt_next = '0;
            skip_next     = 1'b0;
         end
      end
   end

   always_ff @(posedge sysClk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt_reg  <= '0;
         byte_cnt_reg <= '0;
         rx_shift_reg <= '0;
         tx_shift_reg <= '0;
         skip_reg     <= 1'b0;
         byte_out_reg <= '0;
         byte_num_reg <= '0;
         valid_reg    <= 1'b0;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
         ovf_reg      <= 1'b0;
         ack_reg      <= 1'b0;
      end else begin
         bit_cnt_reg  <= bit_cnt_next;
         byte_cnt_reg <= byte_cnt_next;
         rx_shift_reg <= rx_shift_next;
         tx_shift_reg <= tx_shift_next;
         skip_reg     <= skip_next;
         byte_out_reg <= byte_out_next;
         byte_num_reg <= byte_num_next;
         valid_reg    <= valid_next;
         done_reg     <= done_next;
         error_reg    <= error_next;
         ovf_reg      <= ovf_next;
         ack_reg      <= ack_next;
      end
   end

   assign spi_miso        = tx_shift_reg[7];
   assign tx_byte_ack     = ack_reg;
   assign spi_byte        = byte_out_reg;
   assign spi_input_valid = valid_reg;
   assign spi_byte_num    = byte_num_reg;
   assign frame_done      = done_reg;
   assign frame_error     = error_reg;
   assign overflow        = ovf_reg;

endmodule

// File: tb/tb_fpga_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_fpga_spi_slave_rx
// Directed bench: a behavioural SPI master (SCLK = sysClk/10) drives frames;
// a monitor logs every output pulse; one task per scenario checks the result.
// -----------------------------------------------------------------------------
module tb_fpga_spi_slave_rx;

   logic       sysClk   = 1'b0;
   logic       reset_n  = 1'b0;
   logic       spi_sclk = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       spi_mosi = 1'b0;
   logic [7:0] tx_byte  = 8'h00;

   logic       spi_miso;
   logic       tx_byte_ack;
   logic [7:0] spi_byte;
   logic       spi_input_valid;
   logic [3:0] spi_byte_num;
   logic       frame_done;
   logic       frame_error;
   logic       overflow;

   fpga_spi_slave_rx #(
      .FRAME_BYTES (9),
      .SYNC_STAGES (2)
   ) dut (
      .sysClk          (sysClk),
      .reset_n         (reset_n),
      .spi_sclk        (spi_sclk),
      .spi_cs_n        (spi_cs_n),
      .spi_mosi        (spi_mosi),
      .spi_miso        (spi_miso),
      .tx_byte         (tx_byte),
      .tx_byte_ack     (tx_byte_ack),
      .spi_byte        (spi_byte),
      .spi_input_valid (spi_input_valid),
      .spi_byte_num    (spi_byte_num),
      .frame_done      (frame_done),
      .frame_error     (frame_error),
      .overflow        (overflow)
   );

   always #5 sysClk = ~sysClk;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- monitor (sole writer of these) ----------------
   int         valid_cnt = 0;
   int         done_cnt  = 0;
   int         err_cnt   = 0;
   int         ovf_cnt   = 0;
   int         ack_cnt   = 0;
   int         stray_done = 0;
   logic [7:0] done_byte = 8'h00;
   logic [3:0] done_num  = 4'h0;
   logic [7:0] rx_bytes[$];
   logic [3:0] rx_nums[$];

   always @(negedge sysClk) begin
      if (spi_input_valid) begin
         valid_cnt++;
         rx_bytes.push_back(spi_byte);
         rx_nums.push_back(spi_byte_num);
         $display("[%0t] rx byte=%02h num=%0d done=%0b", $time, spi_byte, spi_byte_num, frame_done);
      end
      if (frame_done) begin
         done_cnt++;
         done_byte = spi_byte;
         done_num  = spi_byte_num;
         if (!spi_input_valid) stray_done++;
      end
      if (frame_error) begin
         err_cnt++;
         $display("[%0t] frame_error pulse", $time);
      end
      if (overflow) begin
         ovf_cnt++;
         $display("[%0t] overflow pulse", $time);
      end
      if (tx_byte_ack) ack_cnt++;
   end

   // ---------------- master model ----------------
   logic [7:0] frame_data [0:9];
   logic [7:0] miso_got   [0:9];
   logic [7:0] scratch;

   task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
      got = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         spi_mosi = b[i];
         #50;
         spi_sclk = 1'b1;
         got[i]   = spi_miso;
         #50;
         spi_sclk = 1'b0;
      end
   endtask

   // nbytes full bytes from frame_data, then tail_bits of a partial byte.
   // With gap set, CS stays high for two SCLK periods with SCLK toggling.
   task automatic run_frame(input int nbytes, input int tail_bits, input bit gap);
      spi_cs_n = 1'b0;
      #100;
      for (int k = 0; k < nbytes; k++) send_bits(frame_data[k], 8, miso_got[k]);
      if (tail_bits > 0) send_bits(8'hC3, tail_bits, scratch);
      #100;
      spi_cs_n = 1'b1;
      if (gap) begin
         spi_mosi = 1'b1;
         #50 spi_sclk = 1'b1;
         #50 spi_sclk = 1'b0;
         #50 spi_sclk = 1'b1;
         #50 spi_sclk = 1'b0;
         spi_mosi = 1'b0;
      end else begin
         #100;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int v0, a0;
      reset_n = 1'b0;
      #40;
      n_cmp++;
      if ({spi_miso, tx_byte_ack, spi_input_valid, frame_done, frame_error, overflow} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %06b want 000000",
                  {spi_miso, tx_byte_ack, spi_input_valid, frame_done, frame_error, overflow});
      end
      n_cmp++;
      if (spi_byte !== 8'h00) begin n_bad++; $display("FAIL reset_byte: got %02h want 00", spi_byte); end
      n_cmp++;
      if (spi_byte_num !== 4'h0) begin n_bad++; $display("FAIL reset_num: got %0d want 0", spi_byte_num); end
      v0 = valid_cnt; a0 = ack_cnt;
      reset_n = 1'b1;
      #200;
      n_cmp++;
      if ((valid_cnt - v0) !== 0 || (ack_cnt - a0) !== 0) begin
         n_bad++;
         $display("FAIL reset_idle: got valid=%0d ack=%0d want 0/0", valid_cnt - v0, ack_cnt - a0);
      end
   endtask

   task automatic test_full_frame();
      int v0, d0, e0, o0;
      tx_byte = 8'h5A;
      v0 = valid_cnt; d0 = done_cnt; e0 = err_cnt; o0 = ovf_cnt;
      run_frame(9, 0, 1'b0);
      n_cmp++;
      if ((valid_cnt - v0) !== 9) begin n_bad++; $display("FAIL full_valid_count: got %0d want 9", valid_cnt - v0); end
      if (rx_bytes.size() >= v0 + 9) begin
         for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (rx_bytes[v0 + k] !== frame_data[k] || rx_nums[v0 + k] !== 4'(k)) begin
               n_bad++;
               $display("FAIL full_byte%0d: got %02h/#%0d want %02h/#%0d",
                        k, rx_bytes[v0 + k], rx_nums[v0 + k], frame_data[k], k);
            end
         end
      end
      n_cmp++;
      if ((done_cnt - d0) !== 1 || done_num !== 4'd8 || done_byte !== 8'hAA || stray_done !== 0) begin
         n_bad++;
         $display("FAIL full_done: got cnt=%0d num=%0d byte=%02h stray=%0d want 1/8/aa/0",
                  done_cnt - d0, done_num, done_byte, stray_done);
      end
      n_cmp++;
      if ((err_cnt - e0) !== 0 || (ovf_cnt - o0) !== 0) begin
         n_bad++;
         $display("FAIL full_err_ovf: got err=%0d ovf=%0d want 0/0", err_cnt - e0, ovf_cnt - o0);
      end
   endtask

   task automatic test_miso_echo();
      int a0;
      tx_byte = 8'h5A;
      a0 = ack_cnt;
      run_frame(9, 0, 1'b0);
      for (int k = 0; k < 9; k++) begin
         n_cmp++;
         if (miso_got[k] !== 8'h5A) begin
            n_bad++;
            $display("FAIL miso_byte%0d: got %02h want 5a", k, miso_got[k]);
         end
      end
      n_cmp++;
      if ((ack_cnt - a0) !== 10) begin n_bad++; $display("FAIL miso_ack_count: got %0d want 10", ack_cnt - a0); end
   endtask

   task automatic test_abort();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      run_frame(3, 5, 1'b0);
      n_cmp++;
      if ((valid_cnt - v0) !== 3) begin n_bad++; $display("FAIL abort_valid_count: got %0d want 3", valid_cnt - v0); end
      n_cmp++;
      if ((err_cnt - e0) !== 1) begin n_bad++; $display("FAIL abort_error: got %0d want 1", err_cnt - e0); end
      if (rx_bytes.size() >= v0 + 3) begin
         n_cmp++;
         if (rx_bytes[v0 + 2] !== 8'h8E || rx_nums[v0 + 2] !== 4'd2) begin
            n_bad++;
            $display("FAIL abort_last_byte: got %02h/#%0d want 8e/#2", rx_bytes[v0 + 2], rx_nums[v0 + 2]);
         end
      end
      v0 = valid_cnt; e0 = err_cnt;
      run_frame(9, 0, 1'b0);
      n_cmp++;
      if ((valid_cnt - v0) !== 9 || (err_cnt - e0) !== 0) begin
         n_bad++;
         $display("FAIL abort_next_frame: got valid=%0d err=%0d want 9/0", valid_cnt - v0, err_cnt - e0);
      end
      if (rx_nums.size() >= v0 + 9) begin
         for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (rx_nums[v0 + k] !== 4'(k)) begin
               n_bad++;
               $display("FAIL abort_next_num%0d: got %0d want %0d", k, rx_nums[v0 + k], k);
            end
         end
      end
   endtask

   task automatic test_overlong();
      int v0, d0, e0, o0, a0;
      v0 = valid_cnt; d0 = done_cnt; e0 = err_cnt; o0 = ovf_cnt; a0 = ack_cnt;
      run_frame(10, 0, 1'b0);
      n_cmp++;
      if ((valid_cnt - v0) !== 9 || (done_cnt - d0) !== 1) begin
         n_bad++;
         $display("FAIL long_valid_done: got valid=%0d done=%0d want 9/1", valid_cnt - v0, done_cnt - d0);
      end
      n_cmp++;
      if ((ovf_cnt - o0) !== 1) begin n_bad++; $display("FAIL long_overflow: got %0d want 1", ovf_cnt - o0); end
      n_cmp++;
      if ((err_cnt - e0) !== 0) begin n_bad++; $display("FAIL long_error: got %0d want 0", err_cnt - e0); end
      n_cmp++;
      if (spi_byte !== 8'hAA || spi_byte_num !== 4'd8) begin
         n_bad++;
         $display("FAIL long_hold: got %02h/#%0d want aa/#8", spi_byte, spi_byte_num);
      end
      n_cmp++;
      if ((ack_cnt - a0) !== 11) begin n_bad++; $display("FAIL long_ack_count: got %0d want 11", ack_cnt - a0); end
   endtask

   task automatic test_reset_mid_frame();
      int v0, a0, e0;
      v0 = valid_cnt; a0 = ack_cnt; e0 = err_cnt;
      spi_cs_n = 1'b0;
      #100;
      for (int k = 0; k < 5; k++) send_bits(frame_data[k], 8, miso_got[k]);
      reset_n = 1'b0;
      #20;
      n_cmp++;
      if (spi_byte !== 8'h00 || spi_byte_num !== 4'h0 || spi_miso !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_outputs: got %02h/#%0d/miso=%0b want 00/#0/0", spi_byte, spi_byte_num, spi_miso);
      end
      #20;
      reset_n = 1'b1;
      for (int k = 5; k < 9; k++) send_bits(frame_data[k], 8, miso_got[k]);
      #100;
      spi_cs_n = 1'b1;
      #100;
      n_cmp++;
      if ((valid_cnt - v0) !== 5 || (ack_cnt - a0) !== 6 || (err_cnt - e0) !== 0) begin
         n_bad++;
         $display("FAIL midreset_after: got valid=%0d ack=%0d err=%0d want 5/6/0",
                  valid_cnt - v0, ack_cnt - a0, err_cnt - e0);
      end
      n_cmp++;
      if (spi_byte !== 8'h00 || spi_byte_num !== 4'h0) begin
         n_bad++;
         $display("FAIL midreset_hold: got %02h/#%0d want 00/#0", spi_byte, spi_byte_num);
      end
      v0 = valid_cnt;
      run_frame(9, 0, 1'b0);
      n_cmp++;
      if ((valid_cnt - v0) !== 9) begin n_bad++; $display("FAIL midreset_next_count: got %0d want 9", valid_cnt - v0); end
      if (rx_bytes.size() >= v0 + 9) begin
         for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (rx_bytes[v0 + k] !== frame_data[k] || rx_nums[v0 + k] !== 4'(k)) begin
               n_bad++;
               $display("FAIL midreset_next%0d: got %02h/#%0d want %02h/#%0d",
                        k, rx_bytes[v0 + k], rx_nums[v0 + k], frame_data[k], k);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int v0, d0, e0, o0, a0;
      v0 = valid_cnt; d0 = done_cnt; e0 = err_cnt; o0 = ovf_cnt; a0 = ack_cnt;
      run_frame(9, 0, 1'b1);
      run_frame(9, 0, 1'b0);
      n_cmp++;
      if ((valid_cnt - v0) !== 18 || (done_cnt - d0) !== 2) begin
         n_bad++;
         $display("FAIL b2b_counts: got valid=%0d done=%0d want 18/2", valid_cnt - v0, done_cnt - d0);
      end
      n_cmp++;
      if ((err_cnt - e0) !== 0 || (ovf_cnt - o0) !== 0 || (ack_cnt - a0) !== 20) begin
         n_bad++;
         $display("FAIL b2b_flags: got err=%0d ovf=%0d ack=%0d want 0/0/20",
                  err_cnt - e0, ovf_cnt - o0, ack_cnt - a0);
      end
      if (rx_bytes.size() >= v0 + 18) begin
         for (int k = 0; k < 18; k++) begin
            n_cmp++;
            if (rx_bytes[v0 + k] !== frame_data[k % 9] || rx_nums[v0 + k] !== 4'(k % 9)) begin
               n_bad++;
               $display("FAIL b2b_byte%0d: got %02h/#%0d want %02h/#%0d",
                        k, rx_bytes[v0 + k], rx_nums[v0 + k], frame_data[k % 9], k % 9);
            end
         end
      end
   endtask

   initial begin
      frame_data[0] = 8'h03; frame_data[1] = 8'hA1; frame_data[2] = 8'h8E;
      frame_data[3] = 8'hFE; frame_data[4] = 8'h6F; frame_data[5] = 8'hA6;
      frame_data[6] = 8'h36; frame_data[7] = 8'h1A; frame_data[8] = 8'hAA;
      frame_data[9] = 8'h55;
      for (int k = 0; k < 10; k++) miso_got[k] = 8'h00;

      test_reset();
      test_full_frame();
      test_miso_echo();
      test_abort();
      test_overlong();
      test_reset_mid_frame();
      test_back_to_back();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
